regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the single register-file write port (A3/WD3) between two writeback requesters: ALU pipe and load unit.
// - Fixed priority to ALU; a starvation counter forces a load grant after STARVE_MAX lost cycles.
// - Grants are staged in one output register that drives A3/WD3 directly.
// - Read-side hazard flags cover the staged write for the decode stage.
// - Sits between the execute/memory stages and the register file; owns all writes to it.
// PARAMETERS
// - WIDTH      32            data width; matches register-file width
// - DEPTH      32            number of architectural registers
// - AD_WIDTH   $clog2(DEPTH) register address width
// - STARVE_MAX 3             consecutive load-denied cycles before the load is forced to win (>=1)
// - ZERO_MASK  32'h0000_000D bit i set = register i is hardwired zero (x0,x2,x3); writes to it are discarded
// PORTS
// - clk       in   1         clock
// - rst_n     in   1         reset; one clock; reset is asynchronous and active-low
// - alu_valid in   1         ALU writeback request
// - alu_rd    in   AD_WIDTH  ALU destination register
// - alu_data  in   WIDTH     ALU result
// - alu_ready out  1         ALU request accepted this cycle
// - ld_valid  in   1         load writeback request
// - ld_rd     in   AD_WIDTH  load destination register
// - ld_data   in   WIDTH     load data
// - ld_ready  out  1         load request accepted this cycle
// - A3        out  AD_WIDTH  register-file write address (0 when idle)
// - WD3       out  WIDTH     register-file write data
// - rs1, rs2  in   AD_WIDTH  decode-stage source registers
// - hz1, hz2  out  1         source matches the staged, not-yet-committed write
// BEHAVIOUR
// - Reset: stage valid=0, A3=0, WD3=0, starve_cnt=0. Outputs hz1/hz2 are 0 and both readies follow the combinational rules below.
// - starve_hit = (starve_cnt == STARVE_MAX).
// - alu_ready = !(ld_valid && starve_hit); ld_ready = !alu_valid || starve_hit. Both are combinational.
// - Handshake completes on valid&&ready at a rising edge. Requesters hold valid, rd and data stable until ready.
// - Grant: the winner's rd/data load the stage at the edge. Stage valid = 1 unless ZERO_MASK[rd] is set, in which case the write is dropped and stage valid = 0.
// - No grant leaves stage valid = 0.
// - The stage is single-cycle only; it never holds. A3 = stage valid ? stage rd : 0. WD3 = stage data.
// - Latency: accepted at edge k -> on A3/WD3 during cycle k..k+1 -> committed at edge k+1 -> readable via RD1/RD2 after edge k+1.
// - starve_cnt:
//   - cleared when the load is granted or ld_valid = 0;
//   - incremented when ld_valid && !ld_ready;
//   - saturates at STARVE_MAX.
// - Forced cycle: ALU is stalled for exactly one cycle and the load wins. The counter then restarts from 0.
// - Simultaneous ALU and load writes to the same rd are serialised; the order follows the grant order.
// - hz1 = stage valid && stage rd == rs1 && !ZERO_MASK[rs1]; hz2 is the same for rs2.
// - rs to a zero register never flags a hazard.
// - Reset asserted mid-operation: the staged write is lost and A3 goes to 0 immediately (async). No partial write may be issued.
// CONFIGURATION
// - WB_BYPASS_EN defined:
//   - adds outputs byp1_data, byp2_data (WIDTH), each equal to stage data;
//   - hz1/hz2 are renamed in meaning to "bypass select": decode muxes byp data in place of RD, with no stall.
// - WB_BYPASS_EN undefined:
//   - no bypass ports;
//   - hz1/hz2 mean "stall decode one cycle".
//   - Flag logic is identical in both builds.
// TESTING
// - ALU only: alu_valid=1, rd=5, data=0x1234 -> alu_ready=1. Next cycle A3=5, WD3=0x1234. x5 reads 0x1234 after the following edge.
// - Contention: both valid for 10 cycles with STARVE_MAX=3 -> grant sequence ALU,ALU,ALU,LD,ALU,ALU,ALU,LD,...; alu_ready low exactly on LD cycles.
// - Zero regs: ALU writes rd=0, 2, 3 with data 0xFFFF_FFFF -> alu_ready=1, A3 stays 0, hz never set. Then rd=1 -> A3=1.
// - Hazard: stage holds rd=7 and rs1=7, rs2=8 -> hz1=1, hz2=0. With WB_BYPASS_EN, byp1_data equals the staged data.
// - Reset mid-op: assert rst_n=0 while the stage holds rd=9 -> A3=0 without waiting for a clock edge, starve_cnt=0, x9 unchanged.
// - Load only: ld_valid=1, rd=10, data=0xA5 with alu_valid=0 -> ld_ready=1 in the same cycle, A3=10 the next cycle, starve_cnt stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request/grant bus, register-file write port and decode hazard flags (byp*_data only with WB_BYPASS_EN)
interface regfile_wb_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int AD_WIDTH = 5
);
  logic                alu_valid;
  logic [AD_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]    alu_data;
  logic                alu_ready;
  logic                ld_valid;
  logic [AD_WIDTH-1:0] ld_rd;
  logic [WIDTH-1:0]    ld_data;
  logic                ld_ready;
  logic [AD_WIDTH-1:0] A3;
  logic [WIDTH-1:0]    WD3;
  logic [AD_WIDTH-1:0] rs1;
  logic [AD_WIDTH-1:0] rs2;
  logic                hz1;
  logic                hz2;
`ifdef WB_BYPASS_EN
  logic [WIDTH-1:0]    byp1_data;
  logic [WIDTH-1:0]    byp2_data;
`endif
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
    output alu_ready, ld_ready, A3, WD3, hz1, hz2
`ifdef WB_BYPASS_EN
    , output byp1_data, byp2_data
`endif
  );
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
    input  alu_ready, ld_ready, A3, WD3, hz1, hz2
`ifdef WB_BYPASS_EN
    , input byp1_data, byp2_data
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU-priority writeback arbiter with load starvation guard, staged A3/WD3 and decode hazard flags; WB_BYPASS_EN adds bypass data outputs
module regfile_wb_arbiter #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 32,
  parameter int               AD_WIDTH   = $clog2(DEPTH),
  parameter int               STARVE_MAX = 3,
  parameter logic [DEPTH-1:0] ZERO_MASK  = 32'h0000_000D
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0]       starve_q, starve_d;
  logic                stage_v_q, stage_v_d;
  logic [AD_WIDTH-1:0] stage_rd_q, stage_rd_d;
  logic [WIDTH-1:0]    stage_data_q, stage_data_d;
  logic                starve_hit, alu_go, ld_go;
  // arbitration: ALU wins unless the load has been passed over STARVE_MAX times
  always_comb begin
    starve_hit   = starve_q == SW'(STARVE_MAX);
    alu_go       = bus.alu_valid && !(bus.ld_valid && starve_hit);
    ld_go        = bus.ld_valid && (!bus.alu_valid || starve_hit);
    stage_rd_d   = ld_go ? bus.ld_rd : alu_go ? bus.alu_rd : stage_rd_q;
    stage_data_d = ld_go ? bus.ld_data : alu_go ? bus.alu_data : stage_data_q;
    stage_v_d    = (alu_go || ld_go) && !ZERO_MASK[stage_rd_d];
    starve_d     = (!bus.ld_valid || ld_go) ? '0 : starve_hit ? starve_q : starve_q + 1'b1;
  end
  // single-cycle write stage and starvation counter; async reset drops any staged write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v_q    <= 1'b0;
      stage_rd_q   <= '0;
      stage_data_q <= '0;
      starve_q     <= '0;
    end else begin
      stage_v_q    <= stage_v_d;
      stage_rd_q   <= stage_rd_d;
      stage_data_q <= stage_data_d;
      starve_q     <= starve_d;
    end
  end
  assign bus.alu_ready = !(bus.ld_valid && starve_hit);
  assign bus.ld_ready  = !bus.alu_valid || starve_hit;
  assign bus.A3        = stage_v_q ? stage_rd_q : '0;
  assign bus.WD3       = stage_data_q;
  assign bus.hz1       = stage_v_q && stage_rd_q == bus.rs1 && !ZERO_MASK[bus.rs1];
  assign bus.hz2       = stage_v_q && stage_rd_q == bus.rs2 && !ZERO_MASK[bus.rs2];
`ifdef WB_BYPASS_EN
  assign bus.byp1_data = stage_data_q;
  assign bus.byp2_data = stage_data_q;
`endif
endmodule
